// File: rtl/arb_out_fifo.sv
// arb_out_fifo: tagged first-word-fall-through FIFO behind the arbiter, with a skid-margin fifo_full.
// Defining ARB_FIFO_SRC_CNT_EN adds saturating per-source push counters src0_cnt/src1_cnt.
module arb_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_valid,
    input  logic [DW-1:0]           wr_data,
    input  logic [1:0]              wr_mode,
    input  logic [7:0]              wr_proc_val,
    input  logic                    wr_src,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf_err,
`ifdef ARB_FIFO_SRC_CNT_EN
    output logic [15:0]             src0_cnt,
    output logic [15:0]             src1_cnt,
`endif
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DW-1:0]           rd_data,
    output logic [1:0]              rd_mode,
    output logic [7:0]              rd_proc_val,
    output logic                    rd_src
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] MAX_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - SKID);

    logic [DW+10:0] r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr, r_rd_ptr;
    logic           w_push, w_pop;

    assign level      = r_wr_ptr - r_rd_ptr;
    assign fifo_empty = level == '0;
    assign fifo_full  = level >= FULL_LVL;
    assign rd_valid   = !fifo_empty;
    assign w_pop      = rd_valid && rd_ready;
    // A pop frees the slot at the same edge, so a full FIFO still accepts a push while draining.
    assign w_push     = wr_valid && (level < MAX_LVL || w_pop);
    assign {rd_src, rd_proc_val, rd_mode, rd_data} = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk)
        if (w_push && !flush)
            r_mem[r_wr_ptr[AW-1:0]] <= {wr_src, wr_proc_val, wr_mode, wr_data};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            ovf_err  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (wr_valid && !w_push) ovf_err <= 1'b1;
        end

`ifdef ARB_FIFO_SRC_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            src0_cnt <= '0;
            src1_cnt <= '0;
        end else if (flush) begin
            src0_cnt <= '0;
            src1_cnt <= '0;
        end else if (w_push) begin
            if (!wr_src && src0_cnt != 16'hFFFF) src0_cnt <= src0_cnt + 1'b1;
            if (wr_src && src1_cnt != 16'hFFFF) src1_cnt <= src1_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_arb_out_fifo.sv
// tb_arb_out_fifo: directed table plus hand-written sequences for arb_out_fifo (DW=32, DEPTH=16, SKID=2).
module tb_arb_out_fifo;
    logic        clk = 1'b0;
    logic        rst_n, flush, wr_valid, wr_src, rd_ready;
    logic [31:0] wr_data;
    logic [1:0]  wr_mode;
    logic [7:0]  wr_proc_val;
    logic        fifo_full, fifo_empty, ovf_err, rd_valid, rd_src;
    logic [4:0]  level;
    logic [31:0] rd_data;
    logic [1:0]  rd_mode;
    logic [7:0]  rd_proc_val;
`ifdef ARB_FIFO_SRC_CNT_EN
    logic [15:0] src0_cnt, src1_cnt;
`endif
    int n_chk = 0;
    int n_err = 0;

    arb_out_fifo #(.DW(32), .DEPTH(16), .SKID(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_mode(wr_mode),
        .wr_proc_val(wr_proc_val), .wr_src(wr_src),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .ovf_err(ovf_err),
`ifdef ARB_FIFO_SRC_CNT_EN
        .src0_cnt(src0_cnt), .src1_cnt(src1_cnt),
`endif
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_mode(rd_mode), .rd_proc_val(rd_proc_val), .rd_src(rd_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, wv, rr;
        logic [31:0] d;
        logic [1:0]  m;
        logic [7:0]  pv;
        logic        s;
        logic [4:0]  lvl;
        logic        emp, full, ovf;
        logic [31:0] hd;
        logic [1:0]  hm;
        logic [7:0]  hpv;
        logic        hs;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic w, input logic r, input logic [31:0] d, input logic s);
        flush = f; wr_valid = w; rd_ready = r; wr_data = d;
        wr_mode = d[1:0]; wr_proc_val = d[7:0] ^ 8'h5A; wr_src = s;
        @(posedge clk); #1;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] e, input logic s);
        chk({nm, " data"}, rd_data, e);
        chk({nm, " mode"}, 32'(rd_mode), 32'(e[1:0]));
        chk({nm, " pv"}, 32'(rd_proc_val), 32'(e[7:0] ^ 8'h5A));
        chk({nm, " src"}, 32'(rd_src), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        tv[0] = '{1'b0, 1'b1, 1'b1, 32'hA1, 2'd1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'hA1, 2'd1, 8'h11, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 32'hB2, 2'd2, 8'h22, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'hB2, 2'd2, 8'h22, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b1, 32'hC3, 2'd1, 8'h33, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'hC3, 2'd1, 8'h33, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 8'h00, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b0, 32'hD4, 2'd0, 8'h44, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'hD4, 2'd0, 8'h44, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 32'hE5, 2'd3, 8'h55, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 32'hD4, 2'd0, 8'h44, 1'b1};
        tv[6] = '{1'b1, 1'b1, 1'b1, 32'hF6, 2'd1, 8'h66, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 8'h00, 1'b0};
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_data = '0; wr_mode = '0; wr_proc_val = '0; wr_src = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset level", 32'(level), 32'd0);
        chk("reset empty", 32'(fifo_empty), 32'd1);
        chk("reset full", 32'(fifo_full), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset ovf", 32'(ovf_err), 32'd0);
`ifdef ARB_FIFO_SRC_CNT_EN
        chk("reset src0_cnt", 32'(src0_cnt), 32'd0);
        chk("reset src1_cnt", 32'(src1_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        // Table: in-order FWFT readout with tags, mode-0 storage, flush clearing.
        for (int i = 0; i < 7; i++) begin
            flush = tv[i].fl; wr_valid = tv[i].wv; rd_ready = tv[i].rr;
            wr_data = tv[i].d; wr_mode = tv[i].m; wr_proc_val = tv[i].pv; wr_src = tv[i].s;
            @(posedge clk); #1;
            chk($sformatf("v%0d level", i), 32'(level), 32'(tv[i].lvl));
            chk($sformatf("v%0d empty", i), 32'(fifo_empty), 32'(tv[i].emp));
            chk($sformatf("v%0d full", i), 32'(fifo_full), 32'(tv[i].full));
            chk($sformatf("v%0d ovf", i), 32'(ovf_err), 32'(tv[i].ovf));
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(!tv[i].emp));
            if (!tv[i].emp) begin
                chk($sformatf("v%0d rd_data", i), rd_data, tv[i].hd);
                chk($sformatf("v%0d rd_mode", i), 32'(rd_mode), 32'(tv[i].hm));
                chk($sformatf("v%0d rd_pv", i), 32'(rd_proc_val), 32'(tv[i].hpv));
                chk($sformatf("v%0d rd_src", i), 32'(rd_src), 32'(tv[i].hs));
            end
`ifdef ARB_FIFO_SRC_CNT_EN
            if (i == 2) begin
                chk("s1 src0_cnt", 32'(src0_cnt), 32'd2);
                chk("s1 src1_cnt", 32'(src1_cnt), 32'd1);
            end
            if (i == 6) begin
                chk("flush src0_cnt", 32'(src0_cnt), 32'd0);
                chk("flush src1_cnt", 32'(src1_cnt), 32'd0);
            end
`endif
        end
        // Fill to DEPTH with no reader; fifo_full asserts at DEPTH-SKID.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'(100 + i), i[0]);
            chk($sformatf("fill%0d level", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill%0d full", i), 32'(fifo_full), 32'(i + 1 >= 14));
        end
        chk("fill ovf", 32'(ovf_err), 32'd0);
        chk_head("fill head", 32'd100, 1'b0);
        // Push and pop at level 16: push accepted, no overflow.
        cyc(1'b0, 1'b1, 1'b1, 32'd200, 1'b1);
        chk("pp16 level", 32'(level), 32'd16);
        chk("pp16 ovf", 32'(ovf_err), 32'd0);
        chk_head("pp16 head", 32'd101, 1'b1);
        // Push at level 16 without pop is dropped.
        cyc(1'b0, 1'b1, 1'b0, 32'd300, 1'b0);
        chk("ovf level", 32'(level), 32'd16);
        chk("ovf set", 32'(ovf_err), 32'd1);
        chk_head("ovf head", 32'd101, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
            e = 32'(102 + i);
            chk_head($sformatf("drain%0d", i), e, e[0]);
        end
        chk("drain level", 32'(level), 32'd8);
        chk("ovf sticky", 32'(ovf_err), 32'd1);
        // Flush with a simultaneous write: everything cleared, write not stored.
        cyc(1'b1, 1'b1, 1'b0, 32'd400, 1'b0);
        chk("flush level", 32'(level), 32'd0);
        chk("flush empty", 32'(fifo_empty), 32'd1);
        chk("flush ovf", 32'(ovf_err), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("post-flush level", 32'(level), 32'd0);
        chk("post-flush rd_valid", 32'(rd_valid), 32'd0);
        // Fill to 10 then 40 cycles of streaming; pointers wrap.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 32'(500 + i), i[0]);
        chk("stream start level", 32'(level), 32'd10);
        for (int j = 0; j < 40; j++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'(510 + j), j[0]);
            chk($sformatf("stream%0d level", j), 32'(level), 32'd10);
            e = 32'(501 + j);
            chk_head($sformatf("stream%0d", j), e, e[0]);
        end
        for (int k = 0; k < 10; k++) begin
            e = 32'(540 + k);
            chk_head($sformatf("tail%0d", k), e, e[0]);
            cyc(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        end
        chk("tail empty", 32'(fifo_empty), 32'd1);
        // Asynchronous reset mid-stream at level 5.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'(600 + i), 1'b1);
        chk("pre-rst level", 32'(level), 32'd5);
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async rst rd_valid", 32'(rd_valid), 32'd0);
        chk("async rst level", 32'(level), 32'd0);
        #2;
        rst_n = 1'b1;
`ifdef ARB_FIFO_SRC_CNT_EN
        chk("rst src1_cnt", 32'(src1_cnt), 32'd0);
`endif
        cyc(1'b0, 1'b1, 1'b0, 32'd700, 1'b1);
        chk("after rst rd_valid", 32'(rd_valid), 32'd1);
        chk("after rst level", 32'(level), 32'd1);
        chk_head("after rst", 32'd700, 1'b1);
`ifdef ARB_FIFO_SRC_CNT_EN
        chk("after rst src1_cnt", 32'(src1_cnt), 32'd1);
        chk("after rst src0_cnt", 32'(src0_cnt), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/arb_out_fifo.md
Name: arb_out_fifo

Overview:
- Tagged synchronous FIFO directly downstream of the two-slave arbiter.
- Buffers each arbitrated word together with its mode, processing value and source tag, then presents it first-word-fall-through to the processing engine.
- Drives the arbiter's fifo_full back-pressure with a skid margin. The arbiter registers its output, so it can still deliver words after fifo_full asserts.

Parameters:
- DW, 32, data width.
- DEPTH, 16, entries; power of 2, minimum 4.
- SKID, 2, free entries reserved when fifo_full asserts; range 1..DEPTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_valid  in  1  arbiter slvx_data_valid.
- wr_data  in  DW  arbiter slvx_data.
- wr_mode  in  2  arbiter slvx_mode.
- wr_proc_val  in  8  arbiter slvx_proc_val.
- wr_src  in  1  arbiter data_source (0 = slave0, 1 = slave1).
- fifo_full  out  1  back-pressure to arbiter.
- fifo_empty  out  1  no stored entries.
- level  out  $clog2(DEPTH)+1  current entry count.
- ovf_err  out  1  sticky; a write was dropped.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  DW  head data.
- rd_mode  out  2  head mode.
- rd_proc_val  out  8  head processing value.
- rd_src  out  1  head source tag.

Behaviour:
- Reset, rst_n low (asynchronous):
  - Pointers and level clear to 0; ovf_err = 0.
  - fifo_empty = 1; fifo_full = 0; rd_valid = 0.
  - Storage is not cleared; rd_data, rd_mode, rd_proc_val and rd_src are don't-care while rd_valid = 0.
- Storage:
  - Register array of DW+11 bits per entry.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - level = wr_ptr - rd_ptr, modulo width.
- Push: wr_valid && (level < DEPTH). Entry is written at the clock edge.
- Pop: rd_valid && rd_ready. rd_ptr advances at the clock edge.
- Simultaneous push and pop: both occur; level is unchanged.
  - At level == DEPTH with rd_ready high, the push is accepted because the pop frees the slot that same edge.
- Overflow: wr_valid && level == DEPTH && !pop.
  - The word is dropped and ovf_err sets.
  - ovf_err clears only on reset or flush.
- Combinational status from level:
  - fifo_empty = (level == 0).
  - fifo_full = (level >= DEPTH - SKID).
  - rd_valid = !fifo_empty.
- Read path is first-word-fall-through:
  - rd_* show mem[rd_ptr] combinationally.
  - Write into an empty FIFO gives rd_valid high on the next cycle (1-cycle latency).
- Ordering: strict FIFO; tags always travel with their data.
- flush (synchronous): highest priority.
  - Clears both pointers and ovf_err.
  - A push or pop in the same cycle is ignored.
- Mid-operation reset: rst_n low mid-burst discards all contents immediately, with no glitch requirement on rd_*.
- wr_mode == 0 with wr_valid = 1 is stored like any other value; this block does not filter it.

Optional Feature:
- Macro ARB_FIFO_SRC_CNT_EN.
- When defined, adds outputs src0_cnt (16 bits) and src1_cnt (16 bits):
  - They count accepted pushes whose wr_src is 0 or 1, respectively.
  - Both saturate at 16'hFFFF.
  - Both clear on reset and on flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then push 3 words (src 0, 1, 0; mode 1, 2, 1), rd_ready = 1 -> rd_* return the same words and tags in order; rd_valid first rises 1 cycle after the first push; level returns to 0 and fifo_empty = 1.
2. DEPTH=16, SKID=2, rd_ready = 0, push 14 words -> fifo_full = 1 at level 14; 2 more pushes are accepted (level 16); a 17th push is dropped, ovf_err = 1, level stays 16.
3. Level 16, wr_valid = 1 and rd_ready = 1 for one cycle -> push accepted, level stays 16, ovf_err stays 0, head advances by one.
4. Fill to 10 entries, then run 40 cycles of continuous push+pop -> pointers wrap; level constant at 10; data sequence is intact.
5. Level 8 with ovf_err = 1, assert flush together with wr_valid -> next cycle level = 0, fifo_empty = 1, ovf_err = 0, and the write in the flush cycle is not stored.
6. Pulse rst_n low mid-stream at level 5 -> rd_valid = 0 and level = 0 immediately (asynchronously); after release, a single push reappears 1 cycle later. With ARB_FIFO_SRC_CNT_EN defined, src0_cnt/src1_cnt read 0 after reset and flush, and match the accepted pushes in scenario 1 (src0_cnt = 2, src1_cnt = 1).
